nn_inference_ctrl: RTL

Sequencer in front of the NeuralNetwork core. Collects a 784-pixel grayscale frame from a ready/valid stream into a Q8.8 input buffer. Resets the core, asserts its valid, waits for the argmax result, then presents that result on a ready/valid output. It lets a streaming source (camera, UART, HPS bridge) drive back-to-back inferences without software handling the 12544-bit input vector.

---
 rtl/nn_ctrl_pkg.sv | 35 +++
 rtl/nn_pixel_buffer.sv | 47 ++++
 rtl/nn_inference_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nn_ctrl_pkg
//  Purpose  : Shared types and constants for the NN inference sequencer:
//             controller state encoding, frame size and the Q8.8 pixel
//             conversion helper.
//  Revision : 1.0  initial release
// ============================================================================
package nn_ctrl_pkg;

    // Pixels per frame, one NN input per pixel
    localparam int NUM_PIXELS      = 784;

    // Q8.8 fixed-point layout of an NN input word
    localparam int DATA_INT_WIDTH  = 8;
    localparam int DATA_FRAC_WIDTH = 8;

    // Controller states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        NNRST = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

    // An 8-bit pixel becomes pix/256 in Q8.8: it occupies the fraction bits.
    function automatic logic [DATA_INT_WIDTH+DATA_FRAC_WIDTH-1:0] pix_to_q88(
        input logic [DATA_FRAC_WIDTH-1:0] pix
    );
        return {{DATA_INT_WIDTH{1'b0}}, pix};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_pixel_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : nn_pixel_buffer
//  Purpose  : Flat NN input vector built one word at a time. A clear wipes
//             every word; a write on the same cycle as a clear wins for its
//             own word, so the first pixel of a frame lands in one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module nn_pixel_buffer #(
    parameter int NUM_INPUTS = 784,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clr,
    input  logic                             wr_en,
    input  logic [IDX_W-1:0]                 wr_idx,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] vec
);

    genvar k;
    generate
        for (k = 0; k < NUM_INPUTS; k++) begin : g_word
            logic                  w_hit;
            logic [DATA_WIDTH-1:0] r_word;

            assign w_hit = wr_en && (wr_idx == IDX_W'(k));

            // One word of storage: write beats clear, clear beats hold
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_word <= '0;
                end else if (w_hit) begin
                    r_word <= wr_data;
                end else if (clr) begin
                    r_word <= '0;
                end
            end

            assign vec[k*DATA_WIDTH +: DATA_WIDTH] = r_word;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/nn_inference_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nn_inference_ctrl
//  Purpose  : Sequencer in front of the NeuralNetwork core. Streams a frame
//             of pixels into a Q8.8 input buffer, pulses the core reset,
//             holds nn_valid until the argmax arrives, then offers the
//             result on a ready/valid port.
//  Options  : NNCTRL_TIMEOUT_EN - RUN-state watchdog of TIMEOUT_CYCLES
//             cycles producing a flagged result (res_index='1, value 0).
//  Revision : 1.0  initial release
// ============================================================================
module nn_inference_ctrl
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS     = NUM_PIXELS,
    parameter int DATA_WIDTH     = 16,
    parameter int IDX_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       pix_data,
    input  logic                             pix_valid,
    input  logic                             pix_last,
    output logic                             pix_ready,
    output logic                             nn_reset,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] nn_in,
    output logic                             nn_valid,
    input  logic                             nn_max_valid,
    input  logic [IDX_WIDTH-1:0]             nn_max_index,
    input  logic [15:0]                      nn_max_value,
    output logic [IDX_WIDTH-1:0]             res_index,
    output logic [15:0]                      res_value,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic                             res_timeout,
    output logic                             len_err,
    output logic                             busy,
    output logic [15:0]                      frame_count
);

    localparam int PIX_IDX_W = $clog2(NUM_INPUTS);

    ctrl_state_t            r_state;
    ctrl_state_t            w_state_nxt;

    logic [PIX_IDX_W-1:0]   r_pix_cnt;
    logic                   r_pix_ready;
    logic                   r_nn_reset;
    logic                   r_nn_valid;
    logic                   r_res_valid;
    logic                   r_busy;
    logic                   r_len_err;
    logic [IDX_WIDTH-1:0]   r_res_index;
    logic [15:0]            r_res_value;
    logic [15:0]            r_frame_count;

    logic                   w_pix_ready_nxt;
    logic                   w_nn_reset_nxt;
    logic                   w_nn_valid_nxt;
    logic                   w_res_valid_nxt;
    logic                   w_busy_nxt;

    logic                   w_accept;
    logic                   w_cnt_last;
    logic                   w_frame_end;
    logic                   w_len_bad;
    logic                   w_run_hit;
    logic                   w_to_hit;
    logic                   w_res_hs;
    logic                   w_buf_clr;
    logic [DATA_WIDTH-1:0]  w_pix_word;

    // ------------------------------------------------------------------
    // Handshake and frame-boundary decode
    // ------------------------------------------------------------------
    assign w_accept    = pix_valid && r_pix_ready &&
                         ((r_state == IDLE) || (r_state == LOAD));
    assign w_cnt_last  = (r_pix_cnt == PIX_IDX_W'(NUM_INPUTS - 1));
    // A frame closes on pix_last or on the final slot, whichever is first
    assign w_frame_end = w_accept && (pix_last || w_cnt_last);
    // Well-formed only when pix_last coincides with the final slot
    assign w_len_bad   = w_frame_end && (pix_last != w_cnt_last);
    assign w_run_hit   = (r_state == RUN) && nn_max_valid;
    assign w_res_hs    = (r_state == DONE) && r_res_valid && res_ready;
    assign w_buf_clr   = w_accept && (r_state == IDLE);
    assign w_pix_word  = DATA_WIDTH'(pix_to_q88(pix_data));

    // ------------------------------------------------------------------
    // Optional RUN watchdog
    // ------------------------------------------------------------------
`ifdef NNCTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_res_timeout;

    assign w_to_hit = (r_state == RUN) && !nn_max_valid &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in RUN; held at zero elsewhere so each RUN starts fresh
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (r_state != RUN) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Timeout flag travels with the result and drops on its handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_timeout <= 1'b0;
        end else if (w_run_hit) begin
            r_res_timeout <= 1'b0;
        end else if (w_to_hit) begin
            r_res_timeout <= 1'b1;
        end else if (w_res_hs) begin
            r_res_timeout <= 1'b0;
        end
    end

    assign res_timeout = r_res_timeout;
`else
    logic w_unused_cfg;

    assign w_to_hit     = 1'b0;
    assign res_timeout  = 1'b0;
    assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register plus the registered copies of the decoded outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pix_ready <= 1'b1;
            r_nn_reset  <= 1'b1;
            r_nn_valid  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pix_ready <= w_pix_ready_nxt;
            r_nn_reset  <= w_nn_reset_nxt;
            r_nn_valid  <= w_nn_valid_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_frame_end ? NNRST : LOAD;
                end
            end
            LOAD: begin
                if (w_frame_end) begin
                    w_state_nxt = NNRST;
                end
            end
            NNRST: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (w_run_hit || w_to_hit) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_res_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so every output is a flop
    always_comb begin
        w_pix_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == LOAD);
        w_nn_reset_nxt  = (w_state_nxt == NNRST);
        w_nn_valid_nxt  = (w_state_nxt == RUN);
        w_res_valid_nxt = (w_state_nxt == DONE);
        w_busy_nxt      = (w_state_nxt != IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath: pixel counter, length error, result capture, frame count
    // ------------------------------------------------------------------
    // Pixel slot counter; returns to zero when a frame closes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_cnt <= '0;
        end else if (w_accept) begin
            r_pix_cnt <= w_frame_end ? '0 : (r_pix_cnt + 1'b1);
        end
    end

    // Single-cycle length error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_len_bad;
        end
    end

    // Argmax capture, or the watchdog's flagged result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_index <= '0;
            r_res_value <= '0;
        end else if (w_run_hit) begin
            r_res_index <= nn_max_index;
            r_res_value <= nn_max_value;
        end else if (w_to_hit) begin
            r_res_index <= '1;
            r_res_value <= '0;
        end
    end

    // Completed inferences, free-running wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_res_hs) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    nn_pixel_buffer #(
        .NUM_INPUTS (NUM_INPUTS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (PIX_IDX_W)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_buf_clr),
        .wr_en   (w_accept),
        .wr_idx  (r_pix_cnt),
        .wr_data (w_pix_word),
        .vec     (nn_in)
    );

    assign pix_ready   = r_pix_ready;
    assign nn_reset    = r_nn_reset;
    assign nn_valid    = r_nn_valid;
    assign res_valid   = r_res_valid;
    assign res_index   = r_res_index;
    assign res_value   = r_res_value;
    assign len_err     = r_len_err;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
